// File: rtl/cpu_types_pkg.sv
// Shared types for the core/RAM side of the memory system.
// Provides the RAM word and status types plus the arbiter state and
// requester class encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Order is the arbitration priority: writes, then data reads, then fetches.
    typedef enum logic [1:0] {
        SRC_DW = 2'd0,
        SRC_DR = 2'd1,
        SRC_I  = 2'd2
    } src_class_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the cache-side request ports and the RAM-side port of the arbiter.
//   cache side : iREN/iaddr, dREN/dWEN/daddr/dstore in; iwait/dwait/iload/dload out
//   RAM side   : ramstate/ramload in; ramREN/ramWEN/ramaddr/ramstore out
// slave  = arbiter view, master = caches + RAM view.
interface ram_arbiter_if #(parameter int CPUS = 2);
    import cpu_types_pkg::*;

    logic [CPUS-1:0]  iREN;
    word_t [CPUS-1:0] iaddr;
    logic [CPUS-1:0]  dREN;
    logic [CPUS-1:0]  dWEN;
    word_t [CPUS-1:0] daddr;
    word_t [CPUS-1:0] dstore;
    logic [CPUS-1:0]  iwait;
    logic [CPUS-1:0]  dwait;
    word_t [CPUS-1:0] iload;
    word_t [CPUS-1:0] dload;

    ramstate_t ramstate;
    word_t     ramload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin select: the first requesting core at or after
// the rr pointer wins, returned one-hot.
//   req   : per-core request vector
//   rr    : core index where the search starts
//   grant : one-hot winner, all zero when nothing is requested
module rr_picker #(
    parameter int CPUS = 2,
    parameter int RW   = 1
) (
    input  logic [CPUS-1:0] req,
    input  logic [RW-1:0]   rr,
    output logic [CPUS-1:0] grant
);

    logic          found;
    logic [RW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < CPUS; i++) begin
            idx = RW'((int'(rr) + i) % CPUS);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-ported RAM between the I and D ports of CPUS cores.
// A winner is registered in IDLE and holds the RAM in GRANT until its word,
// or its BURST-word data block, completes.
//   CLK, nRST : clock, synchronous active-low reset
//   bus       : cache request/response signals and the RAM port
//
// state | meaning
// IDLE  | RAM outputs quiet; pick a winner for next cycle
// GRANT | RAM driven by the registered winner until done or abandoned
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter int BURST = 2
) (
    input logic           CLK,
    input logic           nRST,
    ram_arbiter_if.slave  bus
);

    localparam int RW = clog2_min1(CPUS);
    localparam int BW = clog2_min1(BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    arb_state_t    state, state_nxt;
    src_class_t    cls, cls_nxt;
    logic [RW-1:0] core, core_nxt;
    logic [RW-1:0] rr, rr_nxt, rr_inc;
    logic [BW-1:0] beat, beat_nxt;

    logic [CPUS-1:0] dw_oh, dr_oh, i_oh;
    logic            src_en;
    logic [CPUS-1:0] iwait_c, dwait_c;
    word_t [CPUS-1:0] iload_c, dload_c;

    // A core raising both dREN and dWEN is served as a write.
    rr_picker #(.CPUS(CPUS), .RW(RW)) u_pick_dw (.req(bus.dWEN),             .rr(rr), .grant(dw_oh));
    rr_picker #(.CPUS(CPUS), .RW(RW)) u_pick_dr (.req(bus.dREN & ~bus.dWEN), .rr(rr), .grant(dr_oh));
    rr_picker #(.CPUS(CPUS), .RW(RW)) u_pick_i  (.req(bus.iREN),             .rr(rr), .grant(i_oh));

    function automatic logic [RW-1:0] oh2idx(input logic [CPUS-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < CPUS; i++)
            if (oh[i]) oh2idx = RW'(i);
    endfunction

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            cls   <= SRC_DW;
            core  <= '0;
            beat  <= '0;
            rr    <= '0;
        end else begin
            state <= state_nxt;
            cls   <= cls_nxt;
            core  <= core_nxt;
            beat  <= beat_nxt;
            rr    <= rr_nxt;
        end
    end

    assign rr_inc = (core == RW'(CPUS - 1)) ? '0 : core + 1'b1;

    always_comb begin
        state_nxt    = state;
        cls_nxt      = cls;
        core_nxt     = core;
        beat_nxt     = beat;
        rr_nxt       = rr;
        src_en       = 1'b0;
        iwait_c      = '1;
        dwait_c      = '1;
        iload_c      = '0;
        dload_c      = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state)
            IDLE: begin
                if (|dw_oh) begin
                    core_nxt  = oh2idx(dw_oh);
                    cls_nxt   = SRC_DW;
                    state_nxt = GRANT;
                end else if (|dr_oh) begin
                    core_nxt  = oh2idx(dr_oh);
                    cls_nxt   = SRC_DR;
                    state_nxt = GRANT;
                end else if (|i_oh) begin
                    core_nxt  = oh2idx(i_oh);
                    cls_nxt   = SRC_I;
                    state_nxt = GRANT;
                end
            end

            GRANT: begin
                case (cls)
                    SRC_DW: begin
                        src_en       = bus.dWEN[core];
                        bus.ramWEN   = src_en;
                        bus.ramaddr  = bus.daddr[core];
                        bus.ramstore = bus.dstore[core];
                    end
                    SRC_DR: begin
                        src_en       = bus.dREN[core];
                        bus.ramREN   = src_en;
                        bus.ramaddr  = bus.daddr[core];
                        bus.ramstore = bus.dstore[core];
                    end
                    default: begin
                        src_en       = bus.iREN[core];
                        bus.ramREN   = src_en;
                        bus.ramaddr  = bus.iaddr[core];
                    end
                endcase

                if (!src_en) begin
                    // Requester gave up: release the RAM, still pass the turn on.
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                    rr_nxt    = rr_inc;
                end else if (bus.ramstate == ACCESS) begin
                    if (cls == SRC_I) begin
                        iwait_c[core] = 1'b0;
                        iload_c[core] = bus.ramload;
                    end else begin
                        dwait_c[core] = 1'b0;
                        dload_c[core] = bus.ramload;
                    end
                    if (cls == SRC_I || beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                        rr_nxt    = rr_inc;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
                // BUSY/FREE/ERROR: keep the request on the RAM and wait.
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign bus.iwait = iwait_c;
    assign bus.dwait = dwait_c;
    assign bus.iload = iload_c;
    assign bus.dload = dload_c;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam word_t MASK = 32'hFFFF_0000;
    localparam word_t I0 = 32'h0000_0040;
    localparam word_t I1 = 32'h0000_0080;
    localparam word_t A0 = 32'h0000_00A4;
    localparam word_t A1 = 32'h0000_00E0;
    localparam word_t S0 = 32'h1111_2222;
    localparam word_t S1 = 32'hBEEF_DEAD;
    localparam word_t Z  = 32'h0;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    ram_arbiter_if #(.CPUS(2)) bus();

    // RAM model: read data is a fixed function of the address presented.
    assign bus.ramload = bus.ramaddr ^ MASK;

    ram_arbiter #(.CPUS(2), .BURST(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic       nrst;
        logic [1:0] iren, dren, dwen;
        ramstate_t  rs;
        logic       ren, wen;
        word_t      addr, store;
        logic [1:0] iw, dw;
    } vec_t;

    typedef struct {
        logic [65:0]  ram;
        logic [3:0]   waits;
        logic [127:0] loads;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    exp_t sbq[$];

    function automatic vec_t v(input logic nrst, input logic [1:0] iren, dren, dwen,
                               input ramstate_t rs, input logic ren, wen,
                               input word_t addr, store, input logic [1:0] iw, dw);
        vec_t r;
        r.nrst = nrst; r.iren = iren; r.dren = dren; r.dwen = dwen; r.rs = rs;
        r.ren = ren; r.wen = wen; r.addr = addr; r.store = store; r.iw = iw; r.dw = dw;
        return r;
    endfunction

    // Loads are the RAM model's data for whichever port sees wait=0, else 0.
    function automatic exp_t model(input vec_t t);
        exp_t  e;
        word_t il0, il1, dl0, dl1;
        il0 = t.iw[0] ? Z : (t.addr ^ MASK);
        il1 = t.iw[1] ? Z : (t.addr ^ MASK);
        dl0 = t.dw[0] ? Z : (t.addr ^ MASK);
        dl1 = t.dw[1] ? Z : (t.addr ^ MASK);
        e.ram   = {t.ren, t.wen, t.addr, t.store};
        e.waits = {t.iw, t.dw};
        e.loads = {il1, il0, dl1, dl0};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t t);
        exp_t e;
        @(negedge CLK);
        nRST         = t.nrst;
        bus.iREN     = t.iren;
        bus.dREN     = t.dren;
        bus.dWEN     = t.dwen;
        bus.ramstate = t.rs;
        sbq.push_back(model(t));
        #1;
        e = sbq.pop_front();
        chk($sformatf("v%0d_ram", idx),
            128'({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}), 128'(e.ram));
        chk($sformatf("v%0d_waits", idx), 128'({bus.iwait, bus.dwait}), 128'(e.waits));
        chk($sformatf("v%0d_loads", idx),
            {bus.iload[1], bus.iload[0], bus.dload[1], bus.dload[0]}, e.loads);
    endtask

    logic  got;
    int    n;
    word_t ld;

    initial begin
        nRST = 1'b0;
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr[0] = I0;  bus.iaddr[1] = I1;
        bus.daddr[0] = A0;  bus.daddr[1] = A1;
        bus.dstore[0] = S0; bus.dstore[1] = S1;
        bus.ramstate = FREE;
        repeat (2) @(posedge CLK);

        // reset state
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, FREE,   0, 0, Z,  Z,  2'b11, 2'b11));
        // single fetch, core0
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b00, ACCESS, 1, 0, I0, Z,  2'b10, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        // write beats fetch: 2-beat write for core1, then the fetch
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b10, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b10, ACCESS, 0, 1, A1, S1, 2'b11, 2'b01));
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b10, ACCESS, 0, 1, A1, S1, 2'b11, 2'b01));
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b00, ACCESS, 1, 0, I0, Z,  2'b10, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        // both cores reading: grants alternate, 2 beats each
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, A1, S1, 2'b11, 2'b01));
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, A1, S1, 2'b11, 2'b01));
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, A0, S0, 2'b11, 2'b10));
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, A0, S0, 2'b11, 2'b10));
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, A1, S1, 2'b11, 2'b01));
        tbl.push_back(v(1, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, A1, S1, 2'b11, 2'b01));
        // ERROR retry during a core0 read; still exactly 2 ACCESS beats
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b00, ERROR,  1, 0, A0, S0, 2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b00, ERROR,  1, 0, A0, S0, 2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b00, ERROR,  1, 0, A0, S0, 2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b00, ACCESS, 1, 0, A0, S0, 2'b11, 2'b10));
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b00, ACCESS, 1, 0, A0, S0, 2'b11, 2'b10));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        // abandon after beat 0, then a fresh block starts at beat 0
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b00, ACCESS, 1, 0, A0, S0, 2'b11, 2'b10));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, ACCESS, 0, 0, A0, S0, 2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b10, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b10, 2'b00, ACCESS, 1, 0, A1, S1, 2'b11, 2'b01));
        tbl.push_back(v(1, 2'b00, 2'b10, 2'b00, ACCESS, 1, 0, A1, S1, 2'b11, 2'b01));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        // fetch to move rr to 1, then reset mid-write; rr must come back at 0
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b00, ACCESS, 1, 0, I0, Z,  2'b10, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b01, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(0, 2'b00, 2'b00, 2'b01, BUSY,   0, 1, A0, S0, 2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b11, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b11, ACCESS, 0, 1, A0, S0, 2'b11, 2'b10));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b11, ACCESS, 0, 1, A0, S0, 2'b11, 2'b10));
        // dREN+dWEN on one core is a write
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b01, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b01, ACCESS, 0, 1, A0, S0, 2'b11, 2'b10));
        tbl.push_back(v(1, 2'b00, 2'b01, 2'b01, ACCESS, 0, 1, A0, S0, 2'b11, 2'b10));
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, ACCESS, 0, 0, Z,  Z,  2'b11, 2'b11));

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // Core1 fetch held off by BUSY, then completes in the first ACCESS cycle.
        @(negedge CLK);
        bus.iREN = 2'b10; bus.dREN = '0; bus.dWEN = '0; bus.ramstate = BUSY;
        #1 chk("hs_idle_ren", 128'(bus.ramREN), 128'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("hs_busy%0d_ram", k), 128'({bus.ramREN, bus.ramaddr}), 128'({1'b1, I1}));
            chk($sformatf("hs_busy%0d_iwait", k), 128'(bus.iwait), 128'(2'b11));
        end
        @(negedge CLK);
        bus.ramstate = ACCESS;
        got = 1'b0; n = 0; ld = '0;
        while (!got && n < 8) begin
            #1;
            if (bus.iwait[1] == 1'b0) begin
                got = 1'b1;
                ld  = bus.iload[1];
            end else begin
                n++;
                @(negedge CLK);
            end
        end
        chk("hs_iwait_done", 128'(got), 128'(1));
        chk("hs_latency", 128'(n), 128'(0));
        chk("hs_iload", 128'(ld), 128'(I1 ^ MASK));
        @(negedge CLK);
        bus.iREN = '0;
        #1 chk("hs_after_idle", 128'({bus.ramREN, bus.iwait}), 128'({1'b0, 2'b11}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-ported RAM between the instruction and data request ports of CPUS cores.
- Sits between the icache/dcache pairs, on their cache_control_if side, and the cpu_ram_if ram.
- Picks one requester, holds the RAM for it until its word, or its whole dcache block, completes, then re-arbitrates.
- Fairness: data beats instruction; round-robin across cores.

Parameters:
- CPUS, 2: number of cores. Each core has one I port and one D port.
- BURST, 2: words per dcache block transfer. The grant stays locked to a D source for BURST consecutive words.

Ports:
- CLK  in  1  clock; all state updates on posedge
- nRST  in  1  synchronous active-low reset, sampled at posedge CLK
- iREN  in  CPUS  instruction read request per core
- iaddr  in  CPUS x 32  instruction address per core
- dREN  in  CPUS  data read request per core
- dWEN  in  CPUS  data write request per core
- daddr  in  CPUS x 32  data address per core
- dstore  in  CPUS x 32  data write value per core
- iwait  out  CPUS  1 = instruction request not yet complete
- dwait  out  CPUS  1 = data request not yet complete
- iload  out  CPUS x 32  instruction word, valid when iwait=0
- dload  out  CPUS x 32  data word, valid when dwait=0
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from ram
- ramload  in  32  RAM read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data

Behaviour:
- Reset (nRST=0 at posedge):
  - state=IDLE, grant cleared, beat=0, rr pointer=core 0.
  - Outputs: all iwait/dwait=1, iload/dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Sources, in priority order per arbitration:
  1. D-write (dWEN)
  2. D-read (dREN)
  3. I-read (iREN)
  - Within a class, the first requesting core at or after rr wins.
  - dREN and dWEN both high on one core: treat it as a write.
- States:
  - IDLE:
    - RAM outputs are 0.
    - Any request present → register winner (core, class) and go to GRANT next cycle. Nothing is issued to RAM in the IDLE cycle, so arbitration costs 1 cycle.
  - GRANT:
    - ramREN/ramWEN follow the granted source's enable.
    - ramaddr/ramstore are taken combinationally from the granted core's daddr/dstore or iaddr. Every non-granted wait stays 1.
    - ramstate==ACCESS:
      - Granted wait=0 and its load=ramload in the same cycle.
      - I source, or D source with beat==BURST-1 → IDLE next cycle, beat=0, rr=winner core+1 mod CPUS.
      - Otherwise → beat++ and stay in GRANT. The lock holds even if a higher-priority request appears.
    - ramstate==BUSY/FREE: wait=1, hold.
    - ramstate==ERROR: wait=1, stay in GRANT and reissue (retry); beat unchanged.
    - Granted source deasserts its enable: RAM enables drop combinationally that cycle, then → IDLE next cycle with beat=0 (abandon). rr still advances.
- Loads are combinational from ramload and gated by the grant. Non-granted loads are 0.
- beat width: $clog2(BURST) (min 1). It wraps only via the reset to 0 on exit.
- nRST low mid-transfer: everything returns to reset values at that edge; no partial write is completed.
- Latency with single-cycle ACCESS: request→wait=0 in 2 cycles. A 2-word D block takes 3 cycles.

Decomposition:
- cpu_types_pkg provides word_t and ramstate_t.
- Add to cpu_types_pkg:
  - arb_state_t {IDLE, GRANT}
  - src_class_t {SRC_DW, SRC_DR, SRC_I}
- One sub-module, rr_picker: combinational CPUS-wide round-robin select (req vector, rr pointer → one-hot). One instance per class.

Test Plan:
- Only core0 iREN, iaddr=0x40, RAM LAT=0 → ramREN=1 with ramaddr=0x40 in cycle 2; iwait[0]=0 and iload[0]=ramload that cycle; IDLE afterwards.
- Core0 iREN plus core1 dWEN (daddr=0xE0, dstore=0xBEEFDEAD) in the same cycle → D-write served first. ramWEN=1 at 0xE0 for 2 beats (BURST=2), then core0 instruction fetch; iwait[0] stays 1 throughout.
- Core0 and core1 both dREN continuously → grants alternate 0,1,0,1. Each grant covers exactly 2 ACCESS beats.
- ramstate=ERROR for 3 cycles during a dREN at 0xA4 → dwait stays 1; reissue continues until ACCESS; beat count unaffected.
- Core0 drops dREN after beat 0 of a block → ramREN=0 that cycle, IDLE next; a new request is then granted with beat=0.
- nRST=0 asserted while in GRANT with ramWEN=1 → next cycle ramWEN=0, all waits=1, state IDLE, rr=0.
